// File: rtl/fwspi_memio_rcache.sv
// Direct-mapped, one-word-per-line read cache in front of the SPI flash memory-mapped read engine.
// Optional hit/miss counters are built when FWSPI_MEMIO_RCACHE_STATS_EN is defined.
module fwspi_memio_rcache #(
    parameter int LINES = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cpu_valid,
    output logic        cpu_ready,
    input  logic [23:0] cpu_addr,
    output logic [31:0] cpu_rdata,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [23:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        cache_en,
    input  logic        flush
`ifdef FWSPI_MEMIO_RCACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int IDX  = $clog2(LINES);
    localparam int TAGW = 22 - IDX;

    typedef enum logic {
        S_IDLE,
        S_FILL
    } state_t;

    state_t            state_q, state_d;
    logic              cpu_ready_q, cpu_ready_d;
    logic [31:0]       cpu_rdata_q, cpu_rdata_d;
    logic              mem_valid_q, mem_valid_d;
    logic [23:0]       mem_addr_q, mem_addr_d;
    logic [LINES-1:0]  valid_q, valid_d;
    logic              nowrite_q, nowrite_d;

    logic [TAGW-1:0]   tag_q  [LINES];
    logic [31:0]       data_q [LINES];

    logic [IDX-1:0]    cpu_idx, fill_idx;
    logic [TAGW-1:0]   cpu_tag, fill_tag;
    logic              hit, line_we, stat_hit, stat_miss;

    assign cpu_idx  = cpu_addr[IDX+1:2];
    assign cpu_tag  = cpu_addr[23:IDX+2];
    // The fill writes back into the line named by the latched request address.
    assign fill_idx = mem_addr_q[IDX+1:2];
    assign fill_tag = mem_addr_q[23:IDX+2];
    assign hit      = cache_en && valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);

    always_comb begin
        // NOTE: every signal gets a default before the case so no latch can be inferred.
        state_d     = state_q;
        cpu_ready_d = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        mem_valid_d = mem_valid_q;
        mem_addr_d  = mem_addr_q;
        valid_d     = valid_q;
        nowrite_d   = nowrite_q;
        line_we     = 1'b0;
        stat_hit    = 1'b0;
        stat_miss   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (flush) begin
                    valid_d = '0;
                end else if (cpu_valid && !cpu_ready_q) begin
                    if (hit) begin
                        cpu_rdata_d = data_q[cpu_idx];
                        cpu_ready_d = 1'b1;
                        stat_hit    = 1'b1;
                    end else begin
                        mem_valid_d = 1'b1;
                        mem_addr_d  = {cpu_addr[23:2], 2'b00};
                        nowrite_d   = 1'b0;
                        state_d     = S_FILL;
                        stat_miss   = 1'b1;
                    end
                end
            end
            S_FILL: begin
                // A flush while the fill is outstanding must stop it allocating stale data.
                if (flush) begin
                    valid_d   = '0;
                    nowrite_d = 1'b1;
                end
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    cpu_rdata_d = mem_rdata;
                    cpu_ready_d = 1'b1;
                    state_d     = S_IDLE;
                    if (cache_en && !nowrite_q && !flush) begin
                        line_we           = 1'b1;
                        valid_d[fill_idx] = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (!resetn) begin
            state_q     <= S_IDLE;
            cpu_ready_q <= 1'b0;
            cpu_rdata_q <= '0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
            valid_q     <= '0;
            nowrite_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cpu_ready_q <= cpu_ready_d;
            cpu_rdata_q <= cpu_rdata_d;
            mem_valid_q <= mem_valid_d;
            mem_addr_q  <= mem_addr_d;
            valid_q     <= valid_d;
            nowrite_q   <= nowrite_d;
        end
    end

    // NOTE: tag/data arrays are deliberately not reset; the valid bits alone make them meaningful.
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= mem_rdata;
        end
    end

    assign cpu_ready = cpu_ready_q;
    assign cpu_rdata = cpu_rdata_q;
    assign mem_valid = mem_valid_q;
    assign mem_addr  = mem_addr_q;

`ifdef FWSPI_MEMIO_RCACHE_STATS_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;

    always_comb begin
        hit_count_d  = hit_count_q + {31'd0, stat_hit};
        miss_count_d = miss_count_q + {31'd0, stat_miss};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

    logic unused_bits;
    assign unused_bits = ^cpu_addr[1:0];
`else
    logic unused_bits;
    assign unused_bits = ^{cpu_addr[1:0], stat_hit, stat_miss};
`endif

endmodule

// File: tb/tb_fwspi_memio_rcache.sv
// Directed bench for fwspi_memio_rcache: latency-programmable flash model plus a read-data scoreboard.
// Counter checks are included when FWSPI_MEMIO_RCACHE_STATS_EN is defined.
module tb_fwspi_memio_rcache;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cpu_valid;
    logic        cpu_ready;
    logic [23:0] cpu_addr;
    logic [31:0] cpu_rdata;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [23:0] mem_addr;
    logic [31:0] mem_rdata = '0;
    logic        cache_en;
    logic        flush;
`ifdef FWSPI_MEMIO_RCACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    int checks  = 0;
    int errors  = 0;
    int mem_txn = 0;
    int wait_cnt = 0;
    int lat = 3;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    fwspi_memio_rcache #(.LINES(16)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .cpu_valid  (cpu_valid),
        .cpu_ready  (cpu_ready),
        .cpu_addr   (cpu_addr),
        .cpu_rdata  (cpu_rdata),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .cache_en   (cache_en),
        .flush      (flush)
`ifdef FWSPI_MEMIO_RCACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    function automatic logic [31:0] mem_fn(input logic [23:0] a);
        return (a == 24'h000100) ? 32'hDEADBEEF : {8'hA5, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Flash model: raises mem_ready for one cycle after 'lat' wait cycles.
    always @(posedge clk) begin
        if (!resetn) begin
            mem_ready <= 1'b0;
            wait_cnt  <= 0;
        end else begin
            mem_ready <= 1'b0;
            if (mem_valid && !mem_ready) begin
                if (wait_cnt >= lat) begin
                    mem_ready <= 1'b1;
                    mem_rdata <= mem_fn(mem_addr);
                    wait_cnt  <= 0;
                end else begin
                    wait_cnt <= wait_cnt + 1;
                end
            end
            if (mem_valid && mem_ready) mem_txn <= mem_txn + 1;
        end
    end

    // Scoreboard: every cpu_ready pulse retires the oldest expected word.
    always @(negedge clk) begin
        if (resetn && cpu_ready) begin
            check("sb_depth", sb_q.size(), 1);
            if (sb_q.size() != 0) check("rdata", cpu_rdata, sb_q.pop_front());
        end
    end

    // flush_at: 0 = pulse with the request, n>0 = pulse after n edges, <0 = none.
    task automatic do_read(input logic [23:0] a, input bit exp_hit, input int flush_at);
        int n, txn0, exp_n;
        bit got;
        txn0  = mem_txn;
        exp_n = exp_hit ? 1 : (3 + lat + ((flush_at == 0) ? 1 : 0));
        sb_q.push_back(mem_fn(a));
        cpu_addr  = a;
        cpu_valid = 1'b1;
        if (flush_at == 0) flush = 1'b1;
        n   = 0;
        got = 1'b0;
        while (!got && n < 200) begin
            @(posedge clk); #1;
            flush = 1'b0;
            n++;
            if (n == flush_at) flush = 1'b1;
            if (n == 1 && !exp_hit && flush_at != 0) check("miss_mem_valid_n1", mem_valid, 1);
            if (cpu_ready) got = 1'b1;
        end
        check("ready_seen", got, 1);
        check("latency", n, exp_n);
        check("mem_txns", mem_txn - txn0, exp_hit ? 0 : 1);
        if (!got) sb_q.delete();
        cpu_valid = 1'b0;
        flush     = 1'b0;
        @(posedge clk); #1;
        check("ready_pulse", cpu_ready, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        resetn    = 1'b0;
        cpu_valid = 1'b0;
        cpu_addr  = '0;
        cache_en  = 1'b1;
        flush     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cpu_ready", cpu_ready, 0);
        check("rst_mem_valid", mem_valid, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_mem_addr", mem_addr, 0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Cold miss with a slow flash, then a hit
        lat = 20;
        do_read(24'h000100, 1'b0, -1);
        lat = 3;
        do_read(24'h000100, 1'b1, -1);

        // Conflict eviction on index 0
        do_read(24'h000000, 1'b0, -1);
        do_read(24'h000040, 1'b0, -1);
        do_read(24'h000000, 1'b0, -1);

        // Flush while the fill is outstanding
        lat = 8;
        do_read(24'h000204, 1'b0, 3);
        lat = 3;
        do_read(24'h000204, 1'b0, -1);
        do_read(24'h000000, 1'b0, -1);
        do_read(24'h000204, 1'b1, -1);

        // Cache disabled, then re-enabled
        cache_en = 1'b0;
        do_read(24'h000010, 1'b0, -1);
        do_read(24'h000010, 1'b0, -1);
        cache_en = 1'b1;
        do_read(24'h000010, 1'b0, -1);
        do_read(24'h000010, 1'b1, -1);

        // Flush coincident with a hit-eligible request: flush wins, request then misses
        do_read(24'h000010, 1'b0, 0);
        do_read(24'h000010, 1'b1, -1);

        // Request held through the ready cycle is ignored there
        sb_q.push_back(mem_fn(24'h000010));
        cpu_addr  = 24'h000010;
        cpu_valid = 1'b1;
        @(posedge clk); #1;
        check("hold_hit1", cpu_ready, 1);
        @(posedge clk); #1;
        check("hold_ignored", cpu_ready, 0);
        sb_q.push_back(mem_fn(24'h000010));
        @(posedge clk); #1;
        check("hold_hit2", cpu_ready, 1);
        cpu_valid = 1'b0;
        @(posedge clk); #1;
        check("hold_done", cpu_ready, 0);

        // Reset in the middle of a fill
        lat = 10;
        cpu_addr  = 24'h000300;
        cpu_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("fill_pending", mem_valid, 1);
        resetn    = 1'b0;
        cpu_valid = 1'b0;
        sb_q.delete();
        @(posedge clk); #1;
        check("rst_fill_mem_valid", mem_valid, 0);
        check("rst_fill_cpu_ready", cpu_ready, 0);
`ifdef FWSPI_MEMIO_RCACHE_STATS_EN
        check("rst_hit_count", hit_count, 0);
        check("rst_miss_count", miss_count, 0);
`endif
        resetn = 1'b1;
        lat    = 3;
        @(posedge clk); #1;

        // Previously cached line misses; then miss, hit, hit, miss
        do_read(24'h000010, 1'b0, -1);
        do_read(24'h000010, 1'b1, -1);
        do_read(24'h000010, 1'b1, -1);
        do_read(24'h000050, 1'b0, -1);
`ifdef FWSPI_MEMIO_RCACHE_STATS_EN
        check("hit_count", hit_count, 2);
        check("miss_count", miss_count, 2);
`endif

        check("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fwspi_memio_rcache.md
# fwspi_memio_rcache

Direct-mapped read cache between the CPU instruction/data fetch port and the SPI flash memory-mapped read engine (`fwspi_memio`). It serves repeated word reads from local flops and forwards misses to the flash engine's `valid/ready/addr/rdata` port. Loops and literal pools therefore avoid a full SPI command/address/dummy sequence. The block is read-only; flash reconfiguration traffic bypasses it.

## Interface
Parameters:
- `LINES`, default 16. Number of cache lines, each holding one 32-bit word. Must be a power of 2 and at least 2. `IDX = log2(LINES)`.

Ports:
- `clk` in 1: single clock; everything is sampled on the rising edge.
- `resetn` in 1: synchronous, active-low reset.
- `cpu_valid` in 1: read request. Held high, with `cpu_addr` stable, until `cpu_ready`.
- `cpu_ready` out 1: one-cycle pulse; `cpu_rdata` is valid in that cycle.
- `cpu_addr` in 24: byte address. Bits [1:0] are ignored.
- `cpu_rdata` out 32: read data.
- `mem_valid` out 1: registered request to the flash engine.
- `mem_ready` in 1: flash engine data-valid. It may be combinational on `mem_valid`/`mem_addr`.
- `mem_addr` out 24: `{cpu_addr[23:2],2'b00}`.
- `mem_rdata` in 32: flash engine read data.
- `cache_en` in 1: 0 forces every access to miss and suppresses all line writes.
- `flush` in 1: single-cycle pulse that invalidates all lines.

## Operation
Address split:
- Index = `cpu_addr[IDX+1:2]`.
- Tag = `cpu_addr[23:IDX+2]`.

Storage per line: valid bit, tag, data word. All held in flops; no RAM macro.

Hit condition: `cache_en` && valid[index] && tag[index] == tag.

FSM states:
- IDLE:
  - If `flush`, clear all valid bits. No request is evaluated this cycle.
  - Else if `cpu_valid && !cpu_ready`:
    - On a hit: `cpu_rdata <= data[index]`, `cpu_ready <= 1`, remain in IDLE.
    - On a miss: `mem_valid <= 1`, `mem_addr <=` word address, go to FILL.
- FILL:
  - Wait for `mem_ready`.
  - When it arrives: `mem_valid <= 0`, `cpu_rdata <= mem_rdata`, `cpu_ready <= 1`.
  - If `cache_en` and no flush has been seen since entering FILL, write data/tag and set valid[index].
  - Go to IDLE.
- A `flush` during FILL clears all valid bits immediately and sets a pending-no-write flag. The in-flight fill still returns data to the CPU but does not allocate.

## Timing
- Reset (`resetn` = 0 at a clock edge):
  - `cpu_ready` = 0, `mem_valid` = 0, `cpu_rdata` = 0, `mem_addr` = 0.
  - All valid bits = 0, state = IDLE.
  - Tag and data arrays need no reset.
- Reset mid-FILL abandons the fill. The flash engine is reset by its own controls.
- Hit latency: `cpu_ready` is high in cycle N+1 when `cpu_valid` is first high in cycle N.
- Miss latency: `mem_valid` rises in cycle N+1; `cpu_ready` rises one cycle after the cycle in which `mem_ready` is high.
- `cpu_ready` is high for exactly one cycle.
- A request present in the `cpu_ready` cycle is ignored. Back-to-back hits therefore complete every 2 cycles.
- `mem_valid` stays high, with `mem_addr` stable, until `mem_ready`. It is never deasserted early.
- Dropping `cpu_valid` or changing `cpu_addr` before `cpu_ready` is a protocol violation; behaviour is undefined.
- Simultaneous `flush` and a hit-eligible request in IDLE: flush wins, and the request is evaluated next cycle as a miss.
- `cache_en` is sampled each IDLE evaluation and at fill completion.

## Configuration
- `FWSPI_MEMIO_RCACHE_STATS_EN` defined:
  - Adds outputs `hit_count` out 32 and `miss_count` out 32.
  - Each increments by 1 on every evaluated IDLE request: hit or miss respectively.
  - Both wrap modulo 2^32 and reset to 0.
  - `flush` does not clear them.
- Macro undefined: these ports and counters do not exist. Functional behaviour is identical.

## Test plan
- Cold miss then hit:
  - Read 0x000100; memory model returns 0xDEADBEEF after 20 cycles → exactly 1 `mem_valid` transaction and `cpu_rdata` = 0xDEADBEEF.
  - Reread 0x000100 → `cpu_ready` in cycle N+1 with no `mem_valid`.
- Conflict eviction (`LINES` = 16):
  - Read 0x000000, then 0x000040 (same index, different tag) → both miss.
  - Reread 0x000000 → misses again.
- Flush during FILL:
  - Miss on 0x000204 with `flush` pulsed mid-wait → CPU still receives the data.
  - Reread 0x000204 → misses.
- `cache_en` = 0:
  - Read 0x000010 twice → two memory transactions.
  - Set `cache_en` = 1 and read 0x000010 → misses, then hits on the next read.
- Reset mid-FILL:
  - Deassert `resetn` while `mem_valid` = 1 → next cycle `mem_valid` = 0 and `cpu_ready` = 0.
  - Any previously cached address then misses.
- With `FWSPI_MEMIO_RCACHE_STATS_EN`:
  - Sequence miss, hit, hit, miss → `hit_count` = 2, `miss_count` = 2.
